// File: rtl/text_cell_pixel_gen.sv
// Text-mode pixel generator: dual-clock char/attr RAM, external font ROM fetch,
// per-cell colours, character blink and blinking underline cursor (3-cycle pipeline).
module text_cell_pixel_gen #(
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 8,
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int ADDR_W       = 14,
    parameter int BLINK_FRAMES = 30,
    localparam int PX_W        = $clog2(GLYPH_W),
    localparam int LN_W        = $clog2(GLYPH_H)
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 char_write_clock,
    input  logic                 char_write_enable,
    input  logic [ADDR_W-1:0]    char_write_addr,
    input  logic [15:0]          char_write_data,
    input  logic [ADDR_W-1:0]    char_address,
    input  logic [LN_W-1:0]      subchar_line,
    input  logic [PX_W-1:0]      subchar_pixel,
    input  logic                 display_enable,
    input  logic                 frame_start,
    input  logic [ADDR_W-1:0]    cursor_address,
    input  logic                 cursor_enable,
    output logic [8+LN_W-1:0]    font_rom_addr,
    input  logic [GLYPH_W-1:0]   font_rom_data,
    output logic                 pixel_on,
    output logic [3:0]           pixel_color,
    output logic                 pixel_valid
);
    localparam int DEPTH = COLS * ROWS;
    localparam int RA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(GLYPH_W - 1);
    localparam logic [LN_W-1:0]  CUR_LN   = LN_W'(GLYPH_H - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [15:0]       char_mem [DEPTH];
    logic              wr_in_range;
    logic              rd_in_range;
    logic [RA_W-1:0]   rd_idx;

    logic              vld_p1_q, vld_p2_q, vld_p3_q;
    logic              rng_p1_q, rng_p2_q, rng_p3_q;
    logic              cur_p1_q, cur_p2_q, cur_p3_q;
    logic [LN_W-1:0]   ln_p1_q, ln_p2_q, ln_p3_q;
    logic [PX_W-1:0]   px_p1_q, px_p2_q, px_p3_q;
    logic [15:0]       cell_p1_q;
    logic [7:0]        attr_p2_q, attr_p3_q;
    logic [8+LN_W-1:0] font_rom_addr_q;

    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    logic              glyph_bit;
    logic              pixel_on_q, pixel_on_d;
    logic [3:0]        pixel_color_q, pixel_color_d;
    logic              pixel_valid_q;

    assign wr_in_range = {1'b0, char_write_addr} < DEPTH_A;
    assign rd_in_range = {1'b0, char_address} < DEPTH_A;
    // Out-of-range reads are blanked later; steer them to a harmless index.
    assign rd_idx      = rd_in_range ? char_address[RA_W-1:0] : '0;

    always_ff @(posedge char_write_clock) begin
        if (char_write_enable && wr_in_range) begin
            char_mem[char_write_addr[RA_W-1:0]] <= char_write_data;
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: sample timing inputs, read RAM.
    // Stage 2: register cell, drive font ROM address.
    // Stage 3: ROM row valid, select pixel.
    always_ff @(posedge pixel_clock) begin
        cell_p1_q <= char_mem[rd_idx];
        rng_p1_q  <= rd_in_range;
        cur_p1_q  <= cursor_enable && (char_address == cursor_address);
        ln_p1_q   <= subchar_line;
        px_p1_q   <= subchar_pixel;

        rng_p2_q  <= rng_p1_q;
        cur_p2_q  <= cur_p1_q;
        ln_p2_q   <= ln_p1_q;
        px_p2_q   <= px_p1_q;
        attr_p2_q <= cell_p1_q[15:8];

        rng_p3_q  <= rng_p2_q;
        cur_p3_q  <= cur_p2_q;
        ln_p3_q   <= ln_p2_q;
        px_p3_q   <= px_p2_q;
        attr_p3_q <= attr_p2_q;
    end

    // Cursor wins over character blink; blanking and display enable win over both.
    always_comb begin
        glyph_bit = 1'b0;
        if (px_p3_q <= PX_LAST) begin
            glyph_bit = font_rom_data[PX_LAST - px_p3_q];
        end
        if (attr_p3_q[7] && blink_phase_q) begin
            glyph_bit = 1'b0;
        end
        if (cur_p3_q && (ln_p3_q >= CUR_LN) && !blink_phase_q) begin
            glyph_bit = 1'b1;
        end
        pixel_on_d    = 1'b0;
        pixel_color_d = 4'd0;
        if (vld_p3_q && rng_p3_q) begin
            pixel_on_d    = glyph_bit;
            pixel_color_d = glyph_bit ? attr_p3_q[3:0] : {1'b0, attr_p3_q[6:4]};
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            vld_p1_q        <= 1'b0;
            vld_p2_q        <= 1'b0;
            vld_p3_q        <= 1'b0;
            font_rom_addr_q <= '0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
            pixel_on_q      <= 1'b0;
            pixel_color_q   <= 4'd0;
            pixel_valid_q   <= 1'b0;
        end else begin
            vld_p1_q        <= display_enable;
            vld_p2_q        <= vld_p1_q;
            vld_p3_q        <= vld_p2_q;
            font_rom_addr_q <= {cell_p1_q[7:0], ln_p1_q};
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            pixel_on_q      <= pixel_on_d;
            pixel_color_q   <= pixel_color_d;
            pixel_valid_q   <= vld_p3_q;
        end
    end

    assign font_rom_addr = font_rom_addr_q;
    assign pixel_on      = pixel_on_q;
    assign pixel_color   = pixel_color_q;
    assign pixel_valid   = pixel_valid_q;

endmodule
